// File: rtl/psum_pkg.sv
// Shared widths, accumulator type and a constant clog2 helper for the psum accumulator.
package psum_pkg;

    localparam int unsigned DATA_IN_W = 16;
    localparam int unsigned ACC_W     = 24;
    localparam int unsigned OUT_W     = 16;
    localparam int unsigned CNT_W     = 8;

    typedef logic [ACC_W-1:0] acc_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = (v > 1) ? v - 1 : 0;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/psum_fifo.sv
// Small synchronous FIFO with registered head, flags and occupancy; depth must be a power of two.
module psum_fifo
    import psum_pkg::*;
#(
    parameter  int unsigned Width = 16,
    parameter  int unsigned Depth = 2,
    localparam int unsigned CntW  = clog2(Depth + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] din,
    output logic [Width-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CntW-1:0]  count
);

    localparam int unsigned PtrW = clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic [Width-1:0] dout_q, dout_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push & ~full_q;
        do_pop   = pop & ~empty_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        count_d = count_q + CntW'(do_push) - CntW'(do_pop);
        full_d  = (count_d == CntW'(Depth));
        empty_d = (count_d == '0);
        // Head is re-registered so it already reflects a write into an empty FIFO.
        dout_d  = mem_d[rd_ptr_d];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            dout_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            dout_q   <= dout_d;
        end
    end

    assign dout  = dout_q;
    assign full  = full_q;
    assign empty = empty_q;
    assign count = count_q;

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates AccLen non-bubble MAC partial sums per output word and queues results for writeback.
// Define PSUM_SAT_EN to saturate oversized results and expose the sticky SatFlag output.
module psum_accumulator
    import psum_pkg::*;
#(
    parameter int unsigned DataInWidth = DATA_IN_W,
    parameter int unsigned AccWidth    = ACC_W,
    parameter int unsigned OutWidth    = OUT_W,
    parameter int unsigned AccLen      = 9,
    parameter int unsigned FifoDepth   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   NOPIn,
    input  logic [DataInWidth-1:0] DataIn,
    input  logic                   Flush,
    output logic                   InReady,
    output logic                   OutValid,
    input  logic                   OutReady,
    output logic [OutWidth-1:0]    OutData,
    output logic [CNT_W-1:0]       TermCnt
`ifdef PSUM_SAT_EN
    ,
    output logic                   SatFlag
`endif
);

    localparam int unsigned FifoCntW = clog2(FifoDepth + 1);

    logic [AccWidth-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]    term_cnt_q, term_cnt_d;
    logic [AccWidth-1:0] sum;
    logic [AccWidth-1:0] push_val;
    logic [OutWidth-1:0] push_data;
    logic                in_ready;
    logic                accept;
    logic                complete;
    logic                flush_ok;
    logic                push;

    logic                fifo_full;
    logic                fifo_empty;
    logic [FifoCntW-1:0] fifo_count;
    logic [OutWidth-1:0] fifo_dout;

    // Group accumulation, natural completion and early flush.
    always_comb begin
        in_ready   = ~fifo_full;
        accept     = in_ready & ~NOPIn;
        sum        = (term_cnt_q == '0) ? AccWidth'(DataIn) : acc_q + AccWidth'(DataIn);
        complete   = accept && (term_cnt_q == CNT_W'(AccLen - 1));
        flush_ok   = Flush & in_ready;
        push       = complete | (flush_ok & (accept | (term_cnt_q != '0)));
        push_val   = accept ? sum : acc_q;
        acc_d      = acc_q;
        term_cnt_d = term_cnt_q;
        if (push) begin
            acc_d      = '0;
            term_cnt_d = '0;
        end else if (accept) begin
            acc_d      = sum;
            term_cnt_d = term_cnt_q + CNT_W'(1);
        end
    end

`ifdef PSUM_SAT_EN
    logic sat_q, sat_d;
    logic overflow;

    always_comb begin
        overflow  = (push_val[AccWidth-1:OutWidth] != '0);
        push_data = overflow ? '1 : OutWidth'(push_val);
        sat_d     = sat_q | (push & overflow);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign SatFlag = sat_q;
`else
    always_comb begin
        push_data = OutWidth'(push_val);
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q      <= '0;
            term_cnt_q <= '0;
        end else begin
            acc_q      <= acc_d;
            term_cnt_q <= term_cnt_d;
        end
    end

    psum_fifo #(
        .Width (OutWidth),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (OutReady & ~fifo_empty),
        .din   (push_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Full flag and occupancy must never disagree.
    assert property (@(posedge clk) disable iff (!reset)
        fifo_full == (fifo_count == FifoCntW'(FifoDepth)));

    assign InReady  = in_ready;
    assign OutValid = ~fifo_empty;
    assign OutData  = fifo_dout;
    assign TermCnt  = term_cnt_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed self-checking bench for psum_accumulator (default parameters, AccLen = 9, FifoDepth = 2).
module tb_psum_accumulator;

    logic        clk;
    logic        reset;
    logic        NOPIn;
    logic [15:0] DataIn;
    logic        Flush;
    logic        InReady;
    logic        OutValid;
    logic        OutReady;
    logic [15:0] OutData;
    logic [7:0]  TermCnt;
`ifdef PSUM_SAT_EN
    logic        SatFlag;
`endif

    int n_cmp;
    int n_err;

    psum_accumulator dut (
        .clk      (clk),
        .reset    (reset),
        .NOPIn    (NOPIn),
        .DataIn   (DataIn),
        .Flush    (Flush),
        .InReady  (InReady),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .OutData  (OutData),
        .TermCnt  (TermCnt)
`ifdef PSUM_SAT_EN
        ,
        .SatFlag  (SatFlag)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present inputs, then advance past the next rising edge.
    task automatic step(input logic nop, input logic [15:0] d, input logic fl);
        NOPIn  = nop;
        DataIn = d;
        Flush  = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        reset    = 1'b0;
        NOPIn    = 1'b1;
        DataIn   = 16'h0;
        Flush    = 1'b0;
        OutReady = 1'b1;

        #12;
        check_eq("rst_outvalid", 32'(OutValid), 32'd0);
        check_eq("rst_outdata", 32'(OutData), 32'd0);
        check_eq("rst_termcnt", 32'(TermCnt), 32'd0);
        check_eq("rst_inready", 32'(InReady), 32'd1);
`ifdef PSUM_SAT_EN
        check_eq("rst_satflag", 32'(SatFlag), 32'd0);
`endif
        #1 reset = 1'b1;
        step(1'b1, 16'h0, 1'b0);
        check_eq("post_rst_inready", 32'(InReady), 32'd1);

        // Basic group 1..9 -> 45
        for (int i = 1; i <= 8; i++) step(1'b0, 16'(i), 1'b0);
        check_eq("basic_cnt8", 32'(TermCnt), 32'd8);
        check_eq("basic_novalid", 32'(OutValid), 32'd0);
        step(1'b0, 16'd9, 1'b0);
        check_eq("basic_valid", 32'(OutValid), 32'd1);
        check_eq("basic_data", 32'(OutData), 32'd45);
        check_eq("basic_cnt0", 32'(TermCnt), 32'd0);
        step(1'b1, 16'h0, 1'b0);
        check_eq("basic_onecycle", 32'(OutValid), 32'd0);

        // Bubbles carrying 0xFFFF are transparent
        for (int i = 1; i <= 9; i++) begin
            step(1'b1, 16'hFFFF, 1'b0);
            if (i == 5) check_eq("bubble_hold", 32'(TermCnt), 32'd4);
            step(1'b0, 16'(i), 1'b0);
        end
        check_eq("bubble_valid", 32'(OutValid), 32'd1);
        check_eq("bubble_data", 32'(OutData), 32'd45);
        step(1'b1, 16'hFFFF, 1'b0);

        // Flush with a bubble emits the partial sum; a second flush with no terms is a no-op
        step(1'b0, 16'd10, 1'b0);
        step(1'b0, 16'd20, 1'b0);
        step(1'b0, 16'd30, 1'b0);
        check_eq("flush_cnt3", 32'(TermCnt), 32'd3);
        step(1'b1, 16'h0, 1'b1);
        check_eq("flush_valid", 32'(OutValid), 32'd1);
        check_eq("flush_data", 32'(OutData), 32'd60);
        check_eq("flush_cnt0", 32'(TermCnt), 32'd0);
        step(1'b1, 16'h0, 1'b1);
        check_eq("flush_empty_nopush", 32'(OutValid), 32'd0);
        check_eq("flush_empty_cnt", 32'(TermCnt), 32'd0);

        // Flush coinciding with natural completion pushes once
        for (int i = 1; i <= 8; i++) step(1'b0, 16'(i), 1'b0);
        step(1'b0, 16'd9, 1'b1);
        check_eq("flushcomp_data", 32'(OutData), 32'd45);
        step(1'b1, 16'h0, 1'b0);
        check_eq("flushcomp_single", 32'(OutValid), 32'd0);

        // Back-pressure: two groups fill the FIFO, third group stalls
        OutReady = 1'b0;
        for (int i = 1; i <= 9; i++) step(1'b0, 16'(i), 1'b0);
        check_eq("bp_ready_after1", 32'(InReady), 32'd1);
        for (int i = 1; i <= 9; i++) step(1'b0, 16'd2, 1'b0);
        check_eq("bp_ready_full", 32'(InReady), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 16'd3, 1'b0);
        check_eq("bp_stall_cnt", 32'(TermCnt), 32'd0);
        check_eq("bp_head_stable", 32'(OutData), 32'd45);
        OutReady = 1'b1;
        step(1'b0, 16'd3, 1'b0);
        check_eq("bp_pop1_ready", 32'(InReady), 32'd1);
        check_eq("bp_pop1_cnt", 32'(TermCnt), 32'd0);
        check_eq("bp_second_data", 32'(OutData), 32'd18);
        step(1'b0, 16'd3, 1'b0);
        check_eq("bp_pop2_empty", 32'(OutValid), 32'd0);
        check_eq("bp_third_cnt1", 32'(TermCnt), 32'd1);
        for (int i = 0; i < 8; i++) step(1'b0, 16'd3, 1'b0);
        check_eq("bp_third_valid", 32'(OutValid), 32'd1);
        check_eq("bp_third_data", 32'(OutData), 32'd27);
        step(1'b1, 16'h0, 1'b0);

        // Overflow: 9 x 0xFFFF = 0x8FFF7
        for (int i = 0; i < 9; i++) step(1'b0, 16'hFFFF, 1'b0);
`ifdef PSUM_SAT_EN
        check_eq("ovf_data_sat", 32'(OutData), 32'hFFFF);
        check_eq("ovf_satflag", 32'(SatFlag), 32'd1);
`else
        check_eq("ovf_data_trunc", 32'(OutData), 32'hFFF7);
`endif
        step(1'b1, 16'h0, 1'b0);
        for (int i = 1; i <= 9; i++) step(1'b0, 16'(i), 1'b0);
        check_eq("ovf_next_group", 32'(OutData), 32'd45);
`ifdef PSUM_SAT_EN
        check_eq("ovf_satflag_sticky", 32'(SatFlag), 32'd1);
`endif
        step(1'b1, 16'h0, 1'b0);

        // Reset mid-group with a stored entry
        OutReady = 1'b0;
        for (int i = 0; i < 9; i++) step(1'b0, 16'd1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 16'd5, 1'b0);
        check_eq("mid_cnt4", 32'(TermCnt), 32'd4);
        check_eq("mid_stored", 32'(OutData), 32'd9);
        NOPIn = 1'b1;
        #2 reset = 1'b0;
        #1;
        check_eq("mid_rst_valid", 32'(OutValid), 32'd0);
        check_eq("mid_rst_data", 32'(OutData), 32'd0);
        check_eq("mid_rst_cnt", 32'(TermCnt), 32'd0);
`ifdef PSUM_SAT_EN
        check_eq("mid_rst_satflag", 32'(SatFlag), 32'd0);
`endif
        #1 reset = 1'b1;
        OutReady = 1'b1;
        for (int i = 1; i <= 9; i++) step(1'b0, 16'(i), 1'b0);
        check_eq("after_rst_valid", 32'(OutValid), 32'd1);
        check_eq("after_rst_data", 32'(OutData), 32'd45);
        step(1'b1, 16'h0, 1'b0);
        check_eq("after_rst_drain", 32'(OutValid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
